// File: rtl/prime_stream_pkg.sv
// Shared definitions for the prime stream consumer: FSM encoding and default width.
package prime_stream_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GO       = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_WAIT_HI  = 3'd3,
    ST_PUSH     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/prime_stream_if.sv
// Generator handshake and output stream bundle between prime_stream and its neighbours.
interface prime_stream_if
  import prime_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             gen_go;
  logic             gen_ready;
  logic             gen_error;
  logic [WIDTH-1:0] gen_res;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // gen_go is a one-cycle rising edge; the generator drops gen_ready while busy and raises it
  // with gen_res/gen_error valid. The stream transfers out_data when out_valid && out_ready.
  modport master (
    output gen_go, out_valid, out_data,
    input  gen_ready, gen_error, gen_res, out_ready
  );

  modport slave (
    input  gen_go, out_valid, out_data,
    output gen_ready, gen_error, gen_res, out_ready
  );

endinterface

// File: rtl/prime_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
module prime_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the output is defined straight out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/prime_stream.sv
// Drives the prime generator handshake and streams each new prime through a FIFO until a
// count limit, a generator error or a result wrap-around ends the run.
module prime_stream
  import prime_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  prime_stream_if.master   bus,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             err,
  output state_t           state
);

  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] count_inc;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign count_inc     = count + 1'b1;
  assign push          = (state == ST_PUSH) && !full;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !empty;

  prime_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.gen_res),
    .dout  (bus.out_data),
    .full  (full),
    .empty (empty)
  );

  // last_q starts at 1 to match the generator's post-reset result, so 2 is the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bus.gen_go <= 1'b0;
      limit_q    <= '0;
      last_q     <= WIDTH'(1);
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      bus.gen_go <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && !done) begin
            limit_q    <= limit;
            bus.gen_go <= 1'b1;
            state      <= ST_GO;
          end
        end
        ST_GO: state <= ST_WAIT_LOW;
        ST_WAIT_LOW: begin
          if (!bus.gen_ready) state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (bus.gen_ready) begin
            if (bus.gen_error) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (bus.gen_res <= last_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          if (!full) begin
            last_q <= bus.gen_res;
            if (!(&count)) count <= count_inc;
            if ((limit_q != '0) && (count_inc == limit_q)) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (en) begin
              bus.gen_go <= 1'b1;
              state      <= ST_GO;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
